// File: rtl/csi_line_sequencer_if.sv
// Bus bundle between the CSI packet decoder and the line sequencer.
// There is no backpressure: payload_valid_i qualifies payload_i and the sequencer accepts or drops each word based on its line state.
interface csi_line_sequencer_if #(
  parameter int LINE_CNT_W = 12
);
  logic                  frame_start_i;
  logic                  frame_end_i;
  logic                  payload_valid_i;
  logic [31:0]           payload_i;
  logic                  data_valid_o;
  logic [31:0]           data_o;
  logic                  line_valid_o;
  logic                  frame_active_o;
  logic [LINE_CNT_W-1:0] line_count_o;
  logic                  bayer_row_odd_o;
  logic                  short_line_err_o;
  logic                  long_line_err_o;
  logic                  frame_err_o;

  modport master (
    output frame_start_i, frame_end_i, payload_valid_i, payload_i,
    input  data_valid_o, data_o, line_valid_o, frame_active_o, line_count_o,
    input  bayer_row_odd_o, short_line_err_o, long_line_err_o, frame_err_o
  );

  modport slave (
    input  frame_start_i, frame_end_i, payload_valid_i, payload_i,
    output data_valid_o, data_o, line_valid_o, frame_active_o, line_count_o,
    output bayer_row_odd_o, short_line_err_o, long_line_err_o, frame_err_o
  );
endinterface

// File: rtl/csi_line_sequencer.sv
// Line/frame sequencer in front of the raw10 depacker: frames payload lines, enforces post-line flush gaps, tracks Bayer row parity.
// Optional frame line-count check is built when CSI_LINE_SEQ_FRAME_CHECK_EN is defined.
module csi_line_sequencer #(
  parameter int WORDS_PER_LINE  = 5,
  parameter int FLUSH_CYCLES    = 8,
  parameter int LINE_CNT_W      = 12,
  parameter int LINES_PER_FRAME = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  csi_line_sequencer_if.slave  bus,
  output logic [1:0]           state_dbg_o
);

  localparam int WC_W = $clog2(WORDS_PER_LINE + 1);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  if (WORDS_PER_LINE < 2) begin : g_bad_wpl
    $error("WORDS_PER_LINE must be >= 2");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("FLUSH_CYCLES must be >= 1");
  end
  if (LINES_PER_FRAME < 1) begin : g_bad_lpf
    $error("LINES_PER_FRAME must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, FRAME, LINE, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [LINE_CNT_W-1:0] line_count_q, line_count_d;
  logic                  bayer_odd_q, bayer_odd_d;
  logic                  frame_active_q, frame_active_d;
  logic                  pending_fe_q, pending_fe_d;
  logic                  long_seen_q, long_seen_d;
  logic [31:0]           data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  line_valid_q, line_valid_d;
  logic                  short_err_q, short_err_d;
  logic                  long_err_q, long_err_d;

  logic [WC_W-1:0]       word_inc;
  logic [LINE_CNT_W-1:0] line_count_inc;
  logic                  line_done;

  assign word_inc       = word_cnt_q + WC_W'(1);
  assign line_done      = bus.payload_valid_i && (word_inc == WC_W'(WORDS_PER_LINE));
  assign line_count_inc = (&line_count_q) ? line_count_q : line_count_q + LINE_CNT_W'(1);

`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    line_count_d   = line_count_q;
    bayer_odd_d    = bayer_odd_q;
    frame_active_d = frame_active_q;
    pending_fe_d   = pending_fe_q;
    long_seen_d    = long_seen_q;
    data_d         = '0;
    data_valid_d   = 1'b0;
    line_valid_d   = 1'b0;
    short_err_d    = 1'b0;
    long_err_d     = 1'b0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
    frame_err_d    = 1'b0;
`endif

    if (bus.frame_start_i) begin
      // FS from any state (re)opens a frame; mid-frame it silently aborts the line.
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
      frame_err_d    = (state_q != IDLE) && (line_count_q != '0);
`endif
      state_d        = FRAME;
      word_cnt_d     = '0;
      flush_cnt_d    = '0;
      line_count_d   = '0;
      bayer_odd_d    = 1'b0;
      frame_active_d = 1'b1;
      pending_fe_d   = 1'b0;
      long_seen_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        FRAME: begin
          if (bus.frame_end_i) begin
            state_d        = IDLE;
            frame_active_d = 1'b0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
            frame_err_d    = (line_count_q != LINE_CNT_W'(LINES_PER_FRAME));
`endif
          end else if (bus.payload_valid_i) begin
            state_d      = LINE;
            word_cnt_d   = WC_W'(1);
            data_d       = bus.payload_i;
            data_valid_d = 1'b1;
            line_valid_d = 1'b1;
          end
        end
        LINE: begin
          if (bus.payload_valid_i) begin
            word_cnt_d   = word_inc;
            data_d       = bus.payload_i;
            data_valid_d = 1'b1;
            line_valid_d = 1'b1;
          end
          pending_fe_d = pending_fe_q | bus.frame_end_i;
          if (line_done || !bus.payload_valid_i || bus.frame_end_i) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
            long_seen_d = 1'b0;
            short_err_d = !line_done;
          end
        end
        FLUSH: begin
          if (bus.payload_valid_i && !long_seen_q) begin
            long_err_d  = 1'b1;
            long_seen_d = 1'b1;
          end
          pending_fe_d = pending_fe_q | bus.frame_end_i;
          flush_cnt_d  = flush_cnt_q + FC_W'(1);
          if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
            line_count_d = line_count_inc;
            bayer_odd_d  = ~bayer_odd_q;
            word_cnt_d   = '0;
            flush_cnt_d  = '0;
            if (pending_fe_q || bus.frame_end_i) begin
              state_d        = IDLE;
              frame_active_d = 1'b0;
              pending_fe_d   = 1'b0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
              frame_err_d    = (line_count_inc != LINE_CNT_W'(LINES_PER_FRAME));
`endif
            end else begin
              state_d = FRAME;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      flush_cnt_q    <= '0;
      line_count_q   <= '0;
      bayer_odd_q    <= 1'b0;
      frame_active_q <= 1'b0;
      pending_fe_q   <= 1'b0;
      long_seen_q    <= 1'b0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      line_valid_q   <= 1'b0;
      short_err_q    <= 1'b0;
      long_err_q     <= 1'b0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
      frame_err_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      line_count_q   <= line_count_d;
      bayer_odd_q    <= bayer_odd_d;
      frame_active_q <= frame_active_d;
      pending_fe_q   <= pending_fe_d;
      long_seen_q    <= long_seen_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      line_valid_q   <= line_valid_d;
      short_err_q    <= short_err_d;
      long_err_q     <= long_err_d;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
      frame_err_q    <= frame_err_d;
`endif
    end
  end

  assign bus.data_valid_o     = data_valid_q;
  assign bus.data_o           = data_q;
  assign bus.line_valid_o     = line_valid_q;
  assign bus.frame_active_o   = frame_active_q;
  assign bus.line_count_o     = line_count_q;
  assign bus.bayer_row_odd_o  = bayer_odd_q;
  assign bus.short_line_err_o = short_err_q;
  assign bus.long_line_err_o  = long_err_q;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
  assign bus.frame_err_o      = frame_err_q;
`else
  assign bus.frame_err_o      = 1'b0;
`endif
  assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_csi_line_sequencer.sv
// Self-checking bench for csi_line_sequencer: vector table, directed corner cases, and random traffic against a line/frame model.
module tb_csi_line_sequencer;
  localparam int W   = 5;
  localparam int F   = 8;
  localparam int LCW = 12;
  localparam int LPF = 3;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  csi_line_sequencer_if #(.LINE_CNT_W(LCW)) bus();

  csi_line_sequencer #(
    .WORDS_PER_LINE(W), .FLUSH_CYCLES(F), .LINE_CNT_W(LCW), .LINES_PER_FRAME(LPF)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus), .state_dbg_o(state_dbg)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Frame/line bookkeeping with a countdown of remaining blanking cycles.
  bit          m_frame, m_line, m_odd, m_fe_pend, m_long_seen;
  int          m_words, m_blank, m_lines;
  bit          e_dv, e_lv, e_short, e_long, e_ferr;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_frame = 0; m_line = 0; m_odd = 0; m_fe_pend = 0; m_long_seen = 0;
    m_words = 0; m_blank = 0; m_lines = 0;
    e_dv = 0; e_lv = 0; e_short = 0; e_long = 0; e_ferr = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit fs, input bit fe, input bit pv, input logic [31:0] pd);
    e_dv = 0; e_lv = 0; e_short = 0; e_long = 0; e_ferr = 0;
    if (fs) begin
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
      e_ferr = m_frame && (m_lines != 0);
`endif
      m_frame = 1; m_line = 0; m_blank = 0; m_words = 0; m_lines = 0;
      m_odd = 0; m_fe_pend = 0; m_long_seen = 0;
    end else if (m_line) begin
      if (pv) begin
        m_words++; e_dv = 1; e_lv = 1; exp_q.push_back(pd);
      end
      if (fe) m_fe_pend = 1;
      if (!(pv && m_words == W) && (!pv || fe)) e_short = 1;
      if (m_words == W || !pv || fe) begin
        m_line = 0; m_blank = F; m_long_seen = 0;
      end
    end else if (m_blank > 0) begin
      if (pv && !m_long_seen) begin e_long = 1; m_long_seen = 1; end
      if (fe) m_fe_pend = 1;
      m_blank--;
      if (m_blank == 0) begin
        if (m_lines < (1 << LCW) - 1) m_lines++;
        m_odd = !m_odd;
        if (m_fe_pend) begin
          m_frame = 0; m_fe_pend = 0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
          e_ferr = (m_lines != LPF);
`endif
        end
      end
    end else if (m_frame) begin
      if (fe) begin
        m_frame = 0;
`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
        e_ferr = (m_lines != LPF);
`endif
      end else if (pv) begin
        m_line = 1; m_words = 1; e_dv = 1; e_lv = 1; exp_q.push_back(pd);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] w;
    check1("data_valid", 32'(bus.data_valid_o), 32'(e_dv));
    check1("line_valid", 32'(bus.line_valid_o), 32'(e_lv));
    check1("frame_active", 32'(bus.frame_active_o), 32'(m_frame));
    check1("line_count", 32'(bus.line_count_o), 32'(m_lines));
    check1("bayer_odd", 32'(bus.bayer_row_odd_o), 32'(m_odd));
    check1("short_err", 32'(bus.short_line_err_o), 32'(e_short));
    check1("long_err", 32'(bus.long_line_err_o), 32'(e_long));
    check1("frame_err", 32'(bus.frame_err_o), 32'(e_ferr));
    if (bus.data_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data: got %0h expected no word", bus.data_o);
      end else begin
        w = exp_q.pop_front();
        check1("data", bus.data_o, w);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit fs, input bit fe, input bit pv, input logic [31:0] pd);
    @(negedge clk);
    bus.frame_start_i   = fs;
    bus.frame_end_i     = fe;
    bus.payload_valid_i = pv;
    bus.payload_i       = pd;
    @(posedge clk);
    model_step(fs, fe, pv, pd);
    #1 check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
  endtask

  task automatic send_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(0, 0, 1, base + 32'(i) * 32'h0101_0101);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.frame_start_i = 0; bus.frame_end_i = 0; bus.payload_valid_i = 0; bus.payload_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit fs; bit fe; bit pv; logic [31:0] d;
    bit dv; bit lv; bit fa; bit sh; bit lg; int lc;
  } vec_t;
  vec_t tbl[16];

  logic [31:0] nom_words[5];
  int          ferr_cnt;
  int          dens;

  initial begin
    bus.frame_start_i = 0; bus.frame_end_i = 0; bus.payload_valid_i = 0; bus.payload_i = '0;
    model_reset();

    // Short line, drops during flush, exact flush length, second short line, resync.
    tbl[0]  = '{1,0,0,32'h0,        0,0,1,0,0,0};
    tbl[1]  = '{0,0,1,32'h11111111, 1,1,1,0,0,0};
    tbl[2]  = '{0,0,1,32'h22222222, 1,1,1,0,0,0};
    tbl[3]  = '{0,0,1,32'h33333333, 1,1,1,0,0,0};
    tbl[4]  = '{0,0,0,32'h0,        0,0,1,1,0,0};
    tbl[5]  = '{0,0,0,32'h0,        0,0,1,0,0,0};
    tbl[6]  = '{0,0,1,32'h55555555, 0,0,1,0,1,0};
    tbl[7]  = '{0,0,1,32'h66666666, 0,0,1,0,0,0};
    tbl[8]  = '{0,0,0,32'h0,        0,0,1,0,0,0};
    tbl[9]  = '{0,0,0,32'h0,        0,0,1,0,0,0};
    tbl[10] = '{0,0,0,32'h0,        0,0,1,0,0,0};
    tbl[11] = '{0,0,0,32'h0,        0,0,1,0,0,0};
    tbl[12] = '{0,0,0,32'h0,        0,0,1,0,0,1};
    tbl[13] = '{0,0,1,32'h77777777, 1,1,1,0,0,1};
    tbl[14] = '{0,0,0,32'h0,        0,0,1,1,0,1};
    tbl[15] = '{1,0,0,32'h0,        0,0,1,0,0,0};

    nom_words[0] = 32'h12345678; nom_words[1] = 32'h00BCDEF0; nom_words[2] = 32'h12005678;
    nom_words[3] = 32'h9ABC00F0; nom_words[4] = 32'hBBBBBB00;

    // Reset state
    repeat (2) @(negedge clk);
    check1("reset_data_valid", 32'(bus.data_valid_o), 32'h0);
    check1("reset_line_count", 32'(bus.line_count_o), 32'h0);
    check1("reset_frame_active", 32'(bus.frame_active_o), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].fs, tbl[i].fe, tbl[i].pv, tbl[i].d);
      check1($sformatf("tbl%0d_dv", i), 32'(bus.data_valid_o), 32'(tbl[i].dv));
      check1($sformatf("tbl%0d_lv", i), 32'(bus.line_valid_o), 32'(tbl[i].lv));
      check1($sformatf("tbl%0d_fa", i), 32'(bus.frame_active_o), 32'(tbl[i].fa));
      check1($sformatf("tbl%0d_short", i), 32'(bus.short_line_err_o), 32'(tbl[i].sh));
      check1($sformatf("tbl%0d_long", i), 32'(bus.long_line_err_o), 32'(tbl[i].lg));
      check1($sformatf("tbl%0d_lc", i), 32'(bus.line_count_o), 32'(tbl[i].lc));
      if (tbl[i].dv) check1($sformatf("tbl%0d_data", i), bus.data_o, tbl[i].d);
    end
    idle(10);
    step(0, 1, 0, 0);
    idle(2);

    // Nominal frame
    step(1, 0, 0, 0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 5; i++) step(0, 0, 1, nom_words[i]);
      idle(10);
    end
    step(0, 1, 0, 0);
    idle(2);
    check1("nominal_line_count", 32'(bus.line_count_o), 32'd3);
    check1("nominal_frame_active", 32'(bus.frame_active_o), 32'd0);
    check1("nominal_bayer_odd", 32'(bus.bayer_row_odd_o), 32'd1);

    // Long line, then blanking violation
    step(1, 0, 0, 0);
    send_words(6, 32'hA0000000);
    idle(10);
    send_words(5, 32'hB0000000);
    idle(2);
    send_words(10, 32'hC0000000);
    idle(12);

    // FE mid-line after two words
    send_words(2, 32'hD0000000);
    step(0, 1, 0, 0);
    idle(10);
    check1("fe_midline_frame_active", 32'(bus.frame_active_o), 32'd0);

    // Resync during a line
    step(1, 0, 0, 0);
    send_words(5, 32'hE0000000);
    idle(9);
    send_words(3, 32'hE1000000);
    step(1, 0, 0, 0);
    check1("resync_line_valid", 32'(bus.line_valid_o), 32'd0);
    check1("resync_line_count", 32'(bus.line_count_o), 32'd0);
    check1("resync_state_frame", 32'(state_dbg), 32'd1);
    idle(3);

    // Asynchronous reset mid-line
    send_words(2, 32'hF0000000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("async_rst_data_valid", 32'(bus.data_valid_o), 32'd0);
    check1("async_rst_line_valid", 32'(bus.line_valid_o), 32'd0);
    check1("async_rst_frame_active", 32'(bus.frame_active_o), 32'd0);
    check1("async_rst_data", bus.data_o, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

`ifdef CSI_LINE_SEQ_FRAME_CHECK_EN
    // Two-line frame closes with one frame error
    step(1, 0, 0, 0);
    ferr_cnt = 0;
    for (int l = 0; l < 2; l++) begin
      send_words(5, 32'h30000000);
      for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0); if (bus.frame_err_o) ferr_cnt++; end
    end
    step(0, 1, 0, 0); if (bus.frame_err_o) ferr_cnt++;
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0); if (bus.frame_err_o) ferr_cnt++; end
    check1("frame_err_pulse_count", 32'(ferr_cnt), 32'd1);
`endif

    // Randomised traffic
    do_reset();
    dens = 7;
    for (int i = 0; i < 4000; i++) begin
      if (i % 40 == 0) dens = $urandom_range(0, 10);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < dens, $urandom());
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
